rr_arbiter4: RTL and testbench

- Four-requester round-robin arbiter/scheduler sharing one downstream resource (e.g. the 4-to-2 encoder datapath or a shared bus) between four request lines.
- Registered one-hot grant plus a 2-bit encoded grant index, so the resource's select input is driven directly.
- Grant is held until the owner signals done or withdraws its request.
- Fairness comes from a rotating priority pointer.

---
 rtl/rr_arbiter4.sv | 122 ++++++++++++
 tb/tb_rr_arbiter4.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant and encoded index.
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state_reg, state_next;
  logic [1:0] ptr_reg, ptr_next;
  logic [1:0] idx_reg, idx_next;
  logic       timeout_reg, timeout_next;
  logic [1:0] search_ptr;
  logic [3:0] cand_hit;
  logic [1:0] win_off;
  logic [1:0] win_idx;
  logic       win_found;
  logic       release_now;
  logic       force_rel;

  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (64'd1 << CNT_W) <= 64'(MAX_HOLD)) begin : g_bad_cfg
    $error("rr_arbiter4: illegal MAX_HOLD/CNT_W combination");
  end

  // On release the search starts just past the owner, so the owner is tried last.
  assign search_ptr = (state_reg == GRANT) ? idx_reg + 2'd1 : ptr_reg;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_cand
    assign cand_hit[gi] = req[search_ptr + 2'(gi)];
  end

  always_comb begin
    win_off = 2'd0;
    casez (cand_hit)
      4'b???1: win_off = 2'd0;
      4'b??10: win_off = 2'd1;
      4'b?100: win_off = 2'd2;
      4'b1000: win_off = 2'd3;
      default: win_off = 2'd0;
    endcase
  end

  assign win_found = |cand_hit;
  assign win_idx   = search_ptr + win_off;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  assign force_rel = (state_reg == GRANT) && (cnt_reg == CNT_W'(MAX_HOLD - 1));

  // Counts cycles of the current tenure; any release (and thus any new grant) clears it.
  always_comb begin
    cnt_next = '0;
    if (state_reg == GRANT && !release_now)
      cnt_next = cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_next;
  end
`else
  assign force_rel = 1'b0;
`endif

  assign release_now  = (state_reg == GRANT) && (done || !req[idx_reg] || force_rel);
  assign timeout_next = force_rel && !done && req[idx_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      ptr_reg     <= 2'd0;
      idx_reg     <= 2'd0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      idx_reg     <= idx_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    idx_next   = idx_reg;
    if (state_reg == IDLE || release_now) begin
      if (release_now)
        ptr_next = search_ptr;
      if (win_found) begin
        state_next = GRANT;
        idx_next   = win_idx;
      end else begin
        state_next = IDLE;
        idx_next   = 2'd0;
      end
    end
  end

  always_comb begin
    gnt = 4'b0000;
    if (state_reg == GRANT)
      gnt[idx_reg] = 1'b1;
    gnt_idx   = idx_reg;
    gnt_valid = (state_reg == GRANT);
    timeout   = timeout_reg;
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: vector table plus reset and tenure-limit sequences.
module tb_rr_arbiter4;

  localparam int NVEC = 24;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
  } vec_t;

  vec_t vecs [NVEC];

  rr_arbiter4 #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] eg, input logic [1:0] ei,
                     input logic ev, input logic et);
    logic ok;
    ok = (gnt === eg) && (gnt_valid === ev) && (timeout === et) && (!ev || gnt_idx === ei);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got gnt=%b idx=%0d valid=%b timeout=%b, expected gnt=%b idx=%0d valid=%b timeout=%b",
               name, gnt, gnt_idx, gnt_valid, timeout, eg, ei, ev, et);
    end else begin
      $display("ok   %s: gnt=%b idx=%0d valid=%b timeout=%b", name, gnt, gnt_idx, gnt_valid, timeout);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] r);
    rst_n = 1'b0;
    req   = r;
    done  = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Rotation with done every third cycle: 0,1,2,3,0 without idle cycles.
    vecs[0]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1};
    vecs[1]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1};
    vecs[3]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1};
    vecs[4]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1};
    vecs[5]  = '{4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1};
    vecs[6]  = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1};
    vecs[7]  = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1};
    vecs[8]  = '{4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1};
    vecs[9]  = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1};
    vecs[10] = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1};
    vecs[11] = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1};
    // Owner 0 releases, ptr=1 -> 2; owner 2 releases with 0101 -> search 3,0 -> 0.
    vecs[12] = '{4'b0101, 1'b1, 4'b0100, 2'd2, 1'b1};
    vecs[13] = '{4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1};
    vecs[14] = '{4'b0101, 1'b1, 4'b0001, 2'd0, 1'b1};
    // Owner 0 withdraws -> 1; owner 1 withdraws with nothing pending -> idle.
    vecs[15] = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1};
    vecs[16] = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1};
    vecs[17] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
    vecs[18] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
    vecs[19] = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1};
    // Non-owner request arrives mid-tenure, is served only after release.
    vecs[20] = '{4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1};
    vecs[21] = '{4'b1010, 1'b1, 4'b1000, 2'd3, 1'b1};
    vecs[22] = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1};
    // Sole requester is re-granted back to back.
    vecs[23] = '{4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1};

    rst_n = 1'b0;
    req   = 4'b1111;
    done  = 1'b0;
    #2;
    chk("reset_async", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("reset_held_edge", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].req, vecs[i].done);
      chk($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].idx, vecs[i].valid, 1'b0);
    end

    // Asynchronous reset between edges while gnt=1000.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_mid_grant", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    req   = 4'b1000;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("after_reset_1000", 4'b1000, 2'd3, 1'b1, 1'b0);

    // Leave ptr at 2, take a grant, then reset: ptr must return to 0.
    step(4'b0010, 1'b1);
    chk("owner3_to_1", 4'b0010, 2'd1, 1'b1, 1'b0);
    step(4'b0000, 1'b0);
    chk("idle_ptr2", 4'b0000, 2'd0, 1'b0, 1'b0);
    step(4'b0110, 1'b0);
    chk("ptr2_picks_2", 4'b0100, 2'd2, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_ptr2", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ptr_reset_picks_1", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Tenure limit with MAX_HOLD=4 and req=0011, no done.
    do_reset(4'b0011);
    for (int c = 1; c <= 4; c++) begin
      step(4'b0011, 1'b0);
      chk($sformatf("hold_c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
`ifdef ARB_TIMEOUT_EN
    step(4'b0011, 1'b0);
    chk("forced_release", 4'b0010, 2'd1, 1'b1, 1'b1);
    for (int c = 2; c <= 4; c++) begin
      step(4'b0011, 1'b0);
      chk($sformatf("owner1_c%0d", c), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    // done coincides with the limit: ordinary release, no timeout pulse.
    step(4'b0011, 1'b1);
    chk("done_at_limit", 4'b0001, 2'd0, 1'b1, 1'b0);
`else
    for (int c = 5; c <= 8; c++) begin
      step(4'b0011, 1'b0);
      chk($sformatf("hold_c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    step(4'b0011, 1'b1);
    chk("done_after_long_hold", 4'b0010, 2'd1, 1'b1, 1'b0);
`endif
    step(4'b0000, 1'b0);
    chk("final_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
